// File: rtl/mem_access_unit.sv
// Load/store unit in front of data_mem: one request at a time, byte-store
// read-modify-write, load lane select/extension and a valid/ready response.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              MemWrite,
  output logic [15:0]       mem_writeData,
  input  logic [15:0]       mem_readData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic              signed_q, signed_d;
  logic              lane_q, lane_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              accept;
  logic [7:0]        lane_byte;

  assign req_ready     = (state_q == IDLE) && rst_n;
  assign accept        = req_valid && req_ready;
  assign resp_valid    = (state_q == RESP);
  assign MemWrite      = (state_q == WR);
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign lane_byte     = lane_q ? mem_readData[15:8] : mem_readData[7:0];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    byte_d   = byte_q;
    signed_d = signed_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          byte_d   = req_byte;
          signed_d = req_signed;
          lane_d   = req_addr[0];
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          // Misaligned word accesses answer immediately and never touch memory.
          if (!req_byte && req_addr[0]) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            addr_d  = req_addr >> 1;
            wdata_d = req_wdata;
            state_d = (req_write && !req_byte) ? WR : RD;
          end
        end
      end
      RD: begin
        if (cnt_q == LAST_CNT) begin
          if (write_q) begin
            wdata_d = lane_q ? {wdata_q[7:0], mem_readData[7:0]}
                             : {mem_readData[15:8], wdata_q[7:0]};
            state_d = WR;
          end else begin
            rdata_d = byte_q ? {{8{signed_q & lane_byte[7]}}, lane_byte}
                             : mem_readData;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR:   state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      lane_q   <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data_mem, table of transactions with
// a response scoreboard, plus hand sequences for reset, backpressure and abort.
module tb_mem_access_unit;
  localparam int ADDR_W = 16;
  localparam int RD_LAT = 1;

  typedef struct {
    logic        write;
    logic        isByte;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWrCyc;
    logic [15:0] expWrData;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_byte, req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              resp_valid, resp_ready, resp_err;
  logic [15:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic              MemWrite;
  logic [15:0]       mem_writeData, mem_readData;

  logic [15:0] mem [0:65535] = '{default: 16'h0000};
  vec_t        sbQ[$];
  vec_t        vecs[16];
  int          testsRun = 0;
  int          testsFailed = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .MemWrite(MemWrite),
    .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Behavioural data_mem: asynchronous read, write on the strobe edge.
  assign mem_readData = mem[mem_address];
  always @(posedge clk) if (MemWrite) mem[mem_address] <= mem_writeData;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input logic w, input logic b, input logic s,
                          input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
    req_addr = a; req_wdata = d;
  endtask

  task automatic applyStimulus(input vec_t v);
    vec_t        e;
    bit          seen;
    int          cyc, wrCount, wrCyc;
    logic [15:0] wrAddr, wrData;
    @(negedge clk);
    driveReq(v.write, v.isByte, v.sgn, v.addr, v.wdata);
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    sbQ.push_back(v);
    #1 req_valid = 1'b0;
    seen = 0; cyc = 0; wrCount = 0; wrCyc = 0; wrAddr = '0; wrData = '0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (MemWrite) begin
        wrCount++; wrCyc = i; wrAddr = mem_address; wrData = mem_writeData;
      end
      if (resp_valid) begin seen = 1; cyc = i; end
    end
    e = sbQ.pop_front();
    if (!seen) begin
      checkOutput("resp_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("resp_rdata", 32'(resp_rdata), 32'(e.expRdata));
      checkOutput("resp_err", 32'(resp_err), 32'(e.expErr));
      checkOutput("resp_latency", 32'(cyc), 32'(e.expLat));
      checkOutput("memwrite_count", 32'(wrCount), (e.expWrCyc != 0) ? 32'd1 : 32'd0);
      if (e.expWrCyc != 0) begin
        checkOutput("memwrite_cycle", 32'(wrCyc), 32'(e.expWrCyc));
        checkOutput("memwrite_addr", 32'(wrAddr), 32'(e.addr >> 1));
        checkOutput("memwrite_data", 32'(wrData), 32'(e.expWrData));
      end
    end
  endtask

  initial begin
    int cyc;
    //          wr    byte  sgn   addr      wdata     rdata     err  lat wrc wrdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h1234, 16'h0000, 1'b0, 2, 1, 16'h1234};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 2, 0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h00AB, 16'h0000, 1'b0, 3, 2, 16'hAB34};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000, 16'hFFAB, 1'b0, 2, 0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h00AB, 1'b0, 2, 0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'h0034, 1'b0, 2, 0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'hDEAD, 16'h0000, 1'b1, 1, 0, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h55CD, 16'h0000, 1'b0, 3, 2, 16'h00CD};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0077, 16'h0000, 1'b0, 3, 2, 16'h77CD};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h77CD, 1'b0, 2, 0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h00FE, 16'h8001, 16'h0000, 1'b0, 2, 1, 16'h8001};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0080, 1'b0, 2, 0, 16'h0000};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h00FF, 16'h0000, 16'hFF80, 1'b0, 2, 0, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h00FE, 16'h0000, 16'h0001, 1'b0, 2, 0, 16'h0000};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00CD, 1'b0, 2, 0, 16'h0000};

    rst_n = 1'b0; resp_ready = 1'b1;
    driveReq(1'b1, 1'b0, 1'b0, 16'h0002, 16'hFFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_memwrite", 32'(MemWrite), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
      checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
      checkOutput("rst_mem_wdata", 32'(mem_writeData), 32'd0);
    end
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_req_ready", 32'(req_ready), 32'd1);
    checkOutput("release_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("release_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("release_mem_untouched", 32'(mem[1]), 32'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
    checkOutput("misaligned_mem_word2", 32'(mem[2]), 32'd0);
    checkOutput("misaligned_mem_word1", 32'(mem[1]), 32'h0000AB34);

    // Backpressure: hold the load response while a second request waits.
    @(negedge clk);
    resp_ready = 1'b0;
    driveReq(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 20 && cyc == 0; i++) begin
      @(negedge clk);
      if (resp_valid) cyc = i;
    end
    checkOutput("bp_latency", 32'(cyc), 32'd2);
    driveReq(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp_resp_rdata", 32'(resp_rdata), 32'h0000AB34);
      checkOutput("bp_resp_err", 32'(resp_err), 32'd0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_after_hs_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp_after_hs_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_second_busy", 32'(req_ready), 32'd0);
    checkOutput("bp_second_early", 32'(resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("bp_second_valid", 32'(resp_valid), 32'd1);
    checkOutput("bp_second_rdata", 32'(resp_rdata), 32'h000000AB);

    // Reset while a byte store is still reading: memory must stay intact.
    @(negedge clk);
    driveReq(1'b1, 1'b1, 1'b0, 16'h0003, 16'h00FF);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_rd_memwrite", 32'(MemWrite), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_memwrite", 32'(MemWrite), 32'd0);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_req_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_idle_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_idle_memwrite", 32'(MemWrite), 32'd0);
      checkOutput("abort_idle_resp", 32'(resp_valid), 32'd0);
    end
    checkOutput("abort_mem_word1", 32'(mem[1]), 32'h0000AB34);

    for (int i = 8; i < 16; i++) applyStimulus(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
